// File: rtl/bullet_ctrl.sv
// Bullet pool: spawns bullets from the tank on a fire edge, steps them once per frame
// in 1/8-pixel fixed point, reflects them off screen edges and walls, and retires them.
module bullet_ctrl #(
    parameter int unsigned N_BULLETS = 4,
    parameter logic [7:0]  LIFETIME  = 8'd200,
    parameter logic [5:0]  COOLDOWN  = 6'd15,
    parameter logic [2:0]  SPAWN_MUL = 3'd4,
    parameter logic [9:0]  X_MAX     = 10'd639,
    parameter logic [9:0]  Y_MAX     = 10'd479
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      ShootBullet,
    input  logic [9:0]                TankX,
    input  logic [9:0]                TankY,
    input  logic [7:0]                sin,
    input  logic [7:0]                cos,
    input  logic [1:0]                game_end,
    input  logic [N_BULLETS-1:0]      hit,
    input  logic [N_BULLETS-1:0]      wall_x,
    input  logic [N_BULLETS-1:0]      wall_y,
    output logic [10*N_BULLETS-1:0]   BulletX,
    output logic [10*N_BULLETS-1:0]   BulletY,
    output logic [N_BULLETS-1:0]      BulletActive,
    output logic                      Fired
);

    function automatic logic signed [7:0] sm_to_vel(input logic neg, input logic [4:0] mag);
        logic signed [7:0] m;
        m = {3'b000, mag};
        return neg ? -m : m;
    endfunction

    function automatic logic [12:0] spawn_pos(input logic [9:0] c, input logic signed [7:0] v);
        logic [12:0] off;
        off = 13'({{5{v[7]}}, v} * {10'b0, SPAWN_MUL});
        return {c, 3'b000} + off;
    endfunction

    // Bit 13 of the widened sum flags an underflow below zero.
    function automatic logic [13:0] step_sum(input logic [12:0] pos, input logic signed [7:0] v);
        return {1'b0, pos} + {{6{v[7]}}, v};
    endfunction

    function automatic logic out_of_bounds(input logic [13:0] s, input logic [9:0] lim);
        return s[13] || (s[12:3] > lim);
    endfunction

    logic [N_BULLETS-1:0]    act_q, act_d;
    logic [12:0]             px_q [N_BULLETS];
    logic [12:0]             px_d [N_BULLETS];
    logic [12:0]             py_q [N_BULLETS];
    logic [12:0]             py_d [N_BULLETS];
    logic signed [7:0]       vx_q [N_BULLETS];
    logic signed [7:0]       vx_d [N_BULLETS];
    logic signed [7:0]       vy_q [N_BULLETS];
    logic signed [7:0]       vy_d [N_BULLETS];
    logic [7:0]              life_q [N_BULLETS];
    logic [7:0]              life_d [N_BULLETS];
    logic [5:0]              cool_q, cool_d;
    logic                    prev_q, fired_q, fired_d;

    logic [N_BULLETS-1:0]    free, spawn_oh;
    logic                    spawn;
    logic signed [7:0]       spawn_vx, spawn_vy;
    logic [13:0]             sx, sy;
    logic                    unused_angle_lsbs;

    assign unused_angle_lsbs = ^{sin[1:0], cos[1:0]};

    always_comb begin
        free     = ~act_q;
        spawn_oh = free & (~free + N_BULLETS'(1));
        spawn    = ShootBullet && !prev_q && (cool_q == 6'd0) && (game_end == 2'b00) && (|free);
        spawn_vx = sm_to_vel(cos[7], cos[6:2]);
        spawn_vy = sm_to_vel(!sin[7], sin[6:2]);
        fired_d  = spawn;
        act_d    = act_q;
        sx       = '0;
        sy       = '0;

        if (spawn)
            cool_d = COOLDOWN;
        else if (game_end != 2'b00)
            cool_d = 6'd0;
        else if (cool_q != 6'd0)
            cool_d = cool_q - 6'd1;
        else
            cool_d = cool_q;

        for (int i = 0; i < int'(N_BULLETS); i++) begin
            px_d[i]   = px_q[i];
            py_d[i]   = py_q[i];
            vx_d[i]   = vx_q[i];
            vy_d[i]   = vy_q[i];
            life_d[i] = life_q[i];
            sx        = step_sum(px_q[i], vx_q[i]);
            sy        = step_sum(py_q[i], vy_q[i]);
            if (spawn && spawn_oh[i]) begin
                act_d[i]  = 1'b1;
                px_d[i]   = spawn_pos(TankX, spawn_vx);
                py_d[i]   = spawn_pos(TankY, spawn_vy);
                vx_d[i]   = spawn_vx;
                vy_d[i]   = spawn_vy;
                life_d[i] = LIFETIME;
            end else if (act_q[i]) begin
                if ((game_end != 2'b00) || hit[i] || (life_q[i] == 8'd1)) begin
                    act_d[i] = 1'b0;
                end else begin
                    life_d[i] = life_q[i] - 8'd1;
                    if (wall_x[i] || out_of_bounds(sx, X_MAX))
                        vx_d[i] = -vx_q[i];
                    else
                        px_d[i] = sx[12:0];
                    if (wall_y[i] || out_of_bounds(sy, Y_MAX))
                        vy_d[i] = -vy_q[i];
                    else
                        py_d[i] = sy[12:0];
                end
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_q   <= '0;
            cool_q  <= '0;
            prev_q  <= 1'b0;
            fired_q <= 1'b0;
            for (int i = 0; i < int'(N_BULLETS); i++) begin
                px_q[i]   <= '0;
                py_q[i]   <= '0;
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                life_q[i] <= '0;
            end
        end else begin
            act_q   <= act_d;
            cool_q  <= cool_d;
            prev_q  <= ShootBullet;
            fired_q <= fired_d;
            for (int i = 0; i < int'(N_BULLETS); i++) begin
                px_q[i]   <= px_d[i];
                py_q[i]   <= py_d[i];
                vx_q[i]   <= vx_d[i];
                vy_q[i]   <= vy_d[i];
                life_q[i] <= life_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(N_BULLETS); g++) begin : g_out
        assign BulletX[10*g +: 10] = px_q[g][12:3];
        assign BulletY[10*g +: 10] = py_q[g][12:3];
    end

    assign BulletActive = act_q;
    assign Fired        = fired_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: directed scenarios plus randomized frames, compared
// against a behavioural pool model that lives in the bench.
module tb_bullet_ctrl;
    localparam int N    = 4;
    localparam int LIFE = 200;
    localparam int COOL = 15;
    localparam int XMAX = 639;
    localparam int YMAX = 479;

    logic           frame_clk = 1'b0;
    logic           Reset_n;
    logic           ShootBullet;
    logic [9:0]     TankX, TankY;
    logic [7:0]     sin_v, cos_v;
    logic [1:0]     game_end;
    logic [N-1:0]   hit, wall_x, wall_y;
    logic [10*N-1:0] BulletX, BulletY;
    logic [N-1:0]   BulletActive;
    logic           Fired;

    bullet_ctrl #(.N_BULLETS(N)) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .ShootBullet(ShootBullet),
        .TankX(TankX), .TankY(TankY), .sin(sin_v), .cos(cos_v),
        .game_end(game_end), .hit(hit), .wall_x(wall_x), .wall_y(wall_y),
        .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive), .Fired(Fired)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [N-1:0]    act;
        logic            fired;
        logic [10*N-1:0] bx;
        logic [10*N-1:0] by;
    } snap_t;

    typedef struct {
        int slot;
        int x;
        int y;
    } spawn_t;

    snap_t  sb_q[$];
    spawn_t sp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_fired = 0;

    int m_act[N], m_px[N], m_py[N], m_vx[N], m_vy[N], m_life[N];
    int m_cool;
    bit m_prev;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_px[i] = 0; m_py[i] = 0;
            m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
        end
        m_cool = 0;
        m_prev = 0;
    endtask

    // One frame of the pool rules, applied to the inputs currently driven.
    task automatic model_step();
        int slot, nx, ny, vx, vy, tx, ty;
        bit spawn;
        snap_t s;
        spawn_t sp;
        slot = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_act[i] == 0) slot = i;
        spawn = ShootBullet && !m_prev && (m_cool == 0) && (game_end == 0) && (slot >= 0);

        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
                if (game_end != 0 || hit[i] || m_life[i] == 1) begin
                    m_act[i] = 0;
                end else begin
                    m_life[i] = m_life[i] - 1;
                    nx = m_px[i] + m_vx[i];
                    ny = m_py[i] + m_vy[i];
                    if (wall_x[i] || nx < 0 || nx / 8 > XMAX) m_vx[i] = -m_vx[i];
                    else m_px[i] = nx;
                    if (wall_y[i] || ny < 0 || ny / 8 > YMAX) m_vy[i] = -m_vy[i];
                    else m_py[i] = ny;
                end
            end
        end

        if (spawn) begin
            vx = int'(cos_v[6:2]);
            if (cos_v[7]) vx = -vx;
            vy = -int'(sin_v[6:2]);
            if (sin_v[7]) vy = -vy;
            tx = int'(TankX);
            ty = int'(TankY);
            m_px[slot] = (tx * 8 + 4 * vx) & 8191;
            m_py[slot] = (ty * 8 + 4 * vy) & 8191;
            m_vx[slot] = vx;
            m_vy[slot] = vy;
            m_life[slot] = LIFE;
            m_act[slot] = 1;
            m_cool = COOL;
            sp.slot = slot;
            sp.x = m_px[slot] / 8;
            sp.y = m_py[slot] / 8;
            sp_q.push_back(sp);
        end else if (game_end != 0) begin
            m_cool = 0;
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end
        m_prev = ShootBullet;

        s.fired = spawn;
        for (int i = 0; i < N; i++) begin
            s.act[i] = (m_act[i] != 0);
            s.bx[10*i +: 10] = 10'(m_px[i] / 8);
            s.by[10*i +: 10] = 10'(m_py[i] / 8);
        end
        sb_q.push_back(s);
    endtask

    task automatic frame(input logic sh, input logic [1:0] ge, input logic [N-1:0] h,
                         input logic [N-1:0] wx, input logic [N-1:0] wy);
        ShootBullet = sh;
        game_end = ge;
        hit = h;
        wall_x = wx;
        wall_y = wy;
        model_step();
        @(negedge frame_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) frame(1'b0, 2'b00, '0, '0, '0);
    endtask

    task automatic clear_pool();
        frame(1'b0, 2'b01, '0, '0, '0);
    endtask

    task automatic run_monitor();
        snap_t e;
        spawn_t s;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("active", BulletActive, e.act);
                chk("fired", Fired, e.fired);
                chk("bullet_x", BulletX, e.bx);
                chk("bullet_y", BulletY, e.by);
            end
            if (Fired === 1'b1) begin
                n_fired++;
                chk("spawn_pending", sp_q.size() > 0, 1);
                if (sp_q.size() > 0) begin
                    s = sp_q.pop_front();
                    chk("spawn_slot_active", BulletActive[s.slot], 1);
                    chk("spawn_x", BulletX[10*s.slot +: 10], s.x);
                    chk("spawn_y", BulletY[10*s.slot +: 10], s.y);
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cnt;
        logic [N-1:0] h, wx, wy;
        logic [1:0] ge;
        Reset_n = 1'b0;
        ShootBullet = 1'b0;
        TankX = '0; TankY = '0; sin_v = '0; cos_v = '0;
        game_end = '0; hit = '0; wall_x = '0; wall_y = '0;
        model_reset();
        fork
            run_monitor();
        join_none

        @(negedge frame_clk);
        chk("reset_active", BulletActive, 0);
        chk("reset_fired", Fired, 0);
        chk("reset_x", BulletX, 0);
        Reset_n = 1'b1;

        // Spawn and straight-line motion
        TankX = 10'd300; TankY = 10'd250; cos_v = 8'h7F; sin_v = 8'h00;
        frame(1'b1, 2'b00, '0, '0, '0);
        chk("t2_fired", Fired, 1);
        chk("t2_spawn_x", BulletX[9:0], 315);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk("t2_move_x", BulletX[9:0], (2524 + 31 * k) / 8);
        end

        // Held key fires once
        clear_pool();
        base = n_fired;
        repeat (40) frame(1'b1, 2'b00, '0, '0, '0);
        idle(1);
        chk("t3_held_spawns", n_fired - base, 1);

        // Pulses inside the cooldown window
        clear_pool();
        base = n_fired;
        repeat (4) begin
            frame(1'b1, 2'b00, '0, '0, '0);
            idle(9);
        end
        chk("t3_spaced10_spawns", n_fired - base, 2);

        // Pool fills, fifth request dropped
        clear_pool();
        base = n_fired;
        repeat (5) begin
            frame(1'b1, 2'b00, '0, '0, '0);
            idle(15);
        end
        chk("t3_full_spawns", n_fired - base, 4);

        // Kill and spawn in the same frame: spawn dropped, slot reused after the next press
        frame(1'b1, 2'b00, 4'b0100, '0, '0);
        chk("t5_hit_active", BulletActive, 4'b1011);
        chk("t5_hit_fired", Fired, 0);
        idle(1);
        frame(1'b1, 2'b00, '0, '0, '0);
        chk("t5_reuse_fired", Fired, 1);
        chk("t5_reuse_active", BulletActive, 4'b1111);

        // game_end clears the pool; held key must be re-pressed
        idle(1);
        frame(1'b1, 2'b01, '0, '0, '0);
        chk("t6_cleared", BulletActive, 0);
        base = n_fired;
        repeat (5) frame(1'b1, 2'b00, '0, '0, '0);
        chk("t6_held_no_fire", n_fired - base, 0);
        idle(1);
        frame(1'b1, 2'b00, '0, '0, '0);
        chk("t6_repress_fire", n_fired - base, 1);

        // Right-edge reflection, then wall contacts
        clear_pool();
        TankX = 10'd620; TankY = 10'd240; cos_v = 8'h7F; sin_v = 8'h00;
        frame(1'b1, 2'b00, '0, '0, '0);
        chk("t4_x0", BulletX[9:0], 635);
        idle(1);
        chk("t4_x1", BulletX[9:0], 639);
        idle(1);
        chk("t4_x_hold", BulletX[9:0], 639);
        idle(1);
        chk("t4_x_back", BulletX[9:0], 635);
        idle(16);
        cos_v = 8'h00; sin_v = 8'h7F;
        frame(1'b1, 2'b00, '0, '0, '0);
        chk("t4_s1_y", BulletY[19:10], 224);
        frame(1'b0, 2'b00, '0, '0, 4'b0010);
        chk("t4_wall_y_hold", BulletY[19:10], 224);
        idle(1);
        chk("t4_wall_y_down", BulletY[19:10], 228);
        frame(1'b0, 2'b00, '0, 4'b0011, 4'b0011);
        idle(3);

        // Lifetime
        clear_pool();
        TankX = 10'd100; TankY = 10'd100; cos_v = 8'h40; sin_v = 8'h90;
        frame(1'b1, 2'b00, '0, '0, '0);
        cnt = int'(BulletActive[0]);
        repeat (209) begin
            idle(1);
            cnt += int'(BulletActive[0]);
        end
        chk("t5_lifetime_frames", cnt, LIFE);

        // Asynchronous reset with three bullets in flight
        clear_pool();
        cos_v = 8'h9C; sin_v = 8'h33;
        repeat (3) begin
            frame(1'b1, 2'b00, '0, '0, '0);
            idle(15);
        end
        chk("t1_three_live", BulletActive, 4'b0111);
        Reset_n = 1'b0;
        #1;
        chk("t1_async_active", BulletActive, 0);
        chk("t1_async_fired", Fired, 0);
        model_reset();
        @(negedge frame_clk);
        Reset_n = 1'b1;

        // Randomized frames
        for (int f = 0; f < 1500; f++) begin
            TankX = 10'($urandom_range(0, 1023));
            TankY = 10'($urandom_range(0, 1023));
            cos_v = 8'($urandom_range(0, 255));
            sin_v = 8'($urandom_range(0, 255));
            for (int b = 0; b < N; b++) begin
                h[b]  = ($urandom_range(0, 31) == 0);
                wx[b] = ($urandom_range(0, 7) == 0);
                wy[b] = ($urandom_range(0, 7) == 0);
            end
            ge = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            frame($urandom_range(0, 2) == 0, ge, h, wx, wy);
        end

        chk("scoreboard_drained", sb_q.size(), 0);
        chk("spawns_drained", sp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bullet_ctrl.md
Name: bullet_ctrl

Overview:
Bullet pool manager placed directly downstream of a tank controller. It consumes the tank's ShootBullet request, pixel position and the current sin/cos of the turret angle. It spawns bullets into a fixed pool of slots and advances each live bullet once per frame in 1/8-pixel fixed point. Bullets reflect off screen edges and off wall flags from the collision block, and are retired on hit, lifetime expiry or game end. The packed position and active outputs feed the colour mapper and the hit detector.

Parameters:
N_BULLETS, 4, number of bullet slots (1..8)
LIFETIME, 8'd200, frames a bullet lives after spawn
COOLDOWN, 6'd15, frames after a spawn during which new requests are dropped
SPAWN_MUL, 3'd4, spawn offset from tank centre as a multiple of the per-frame velocity
X_MAX, 10'd639, rightmost pixel
Y_MAX, 10'd479, bottom pixel

Ports:
frame_clk  in  1  frame clock; all state updates on its rising edge
Reset_n  in  1  asynchronous, active-low reset
ShootBullet  in  1  level request from the tank; held high while the fire key is down
TankX, TankY  in  10 each  tank centre in pixels
sin, cos  in  8 each  sign-magnitude; bit7 = 1 means negative; bits[6:0] = magnitude
game_end  in  2  nonzero = clear all bullets, suppress firing
hit  in  N_BULLETS  per-slot kill request from the hit detector
wall_x, wall_y  in  N_BULLETS each  per-slot vertical-wall / horizontal-wall contact
BulletX, BulletY  out  10*N_BULLETS each  pixel position of slot i at bits [10i+9:10i]
BulletActive  out  N_BULLETS  slot i live
Fired  out  1  one-cycle pulse on a successful spawn

Behaviour:
- Reset_n low (async): all slots inactive; positions, velocities and lifetimes 0; cooldown 0; shoot_prev 0; Fired 0.
- Per-slot state: pos_x and pos_y, each 13-bit unsigned (pixel = pos[12:3]); vel_x and vel_y, each 8-bit two's complement in 1/8 px per frame; life, 8-bit.
- Velocity at spawn: vx = +cos[6:2] and vy = −sin[6:2]. Each is a 5-bit magnitude, so at most 31/8 px per frame. When bit7 = 1 the sign flips. vy is negated because screen Y grows downward.
- Fire request = ShootBullet & ~shoot_prev (rising edge). shoot_prev is registered every cycle.
- Spawn occurs when all hold: request, cooldown == 0, game_end == 0, and at least one free slot.
- The free mask is sampled before this cycle's kills. A slot freed this cycle is reusable from the next cycle.
- The lowest-index free slot is chosen.
- Spawn slot init: pos_x = {TankX,3'b0} + SPAWN_MUL*vx, and likewise for y. All arithmetic is 13-bit with sign extension.
- Spawn slot init continued: life = LIFETIME, active = 1, cooldown = COOLDOWN, Fired = 1 for this cycle.
- A request that fails any condition is dropped; it is not queued. A held ShootBullet never re-fires.
- Cooldown decrements by 1 per frame while nonzero, saturating at 0.
- Per live slot, each frame, priority high→low:
  1. game_end != 0 → inactive.
  2. hit[i] → inactive.
  3. life == 1 → inactive (expired). Otherwise life decrements by 1.
  4. Move on X: nx = pos_x + vx. If wall_x[i], or nx[12:3] > X_MAX, or nx would underflow below 0 (sign of 14-bit sum), then vel_x is negated and pos_x holds. Otherwise pos_x = nx.
  5. Move on Y: same rule using wall_y[i] and Y_MAX.
  6. X and Y are evaluated independently in the same cycle, so a corner contact reflects both components.
- Spawn position outside the screen: the bullet is still spawned. It reflects on its first move.
- Inactive slots: position, velocity and life hold their last values. BulletActive = 0. Downstream blocks must gate on BulletActive.
- game_end != 0: all slots are cleared and cooldown is forced to 0, but shoot_prev still tracks. A key held across game_end release therefore does not fire.
- Latency: a request on edge k produces BulletActive high and Fired high after edge k. The bullet's first motion step happens at edge k+1.
- hit or wall flags on an inactive slot are ignored.

Test Plan:
1. Reset_n low mid-flight with 3 slots active → all BulletActive = 0 immediately, without waiting for a clock edge. Fired = 0.
2. Spawn and motion: TankX = 300, TankY = 250, cos = 8'h7F, sin = 8'h00, one ShootBullet pulse.
   - Slot0 active, Fired pulses once, BulletX[9:0] = 315 (offset 124/8 = 15.5 px, truncated).
   - Each following frame, pos_x increases by 31 eighths.
3. Cooldown and hold:
   - ShootBullet held high for 40 frames → exactly 1 spawn.
   - Pulses spaced 10 frames apart → only every second pulse spawns (COOLDOWN = 15).
   - Pulses spaced 16 frames apart → 4 spawns fill slots 0–3; a 5th pulse is dropped (Fired stays 0).
4. Reflection:
   - Bullet with vx = +31 at pixel 637 → next frame vel_x = −31 and position holds; it then moves left.
   - wall_y[1] asserted → slot1 vel_y negated the same frame.
   - wall_x and wall_y both asserted → both components negated.
5. Lifetime and hit:
   - Bullet spawned at frame 0 goes inactive after edge 200.
   - hit[2] asserted → slot2 inactive next edge. A spawn request in the same cycle with all other slots full is dropped, then succeeds into slot2 one frame later.
6. game_end = 2'b01 with 4 live bullets → all inactive next edge and ShootBullet ignored. After game_end returns to 0 with ShootBullet still held, no spawn occurs until ShootBullet has been released and pressed again.
